// File: rtl/rtc_pkg.sv
// rtc_pkg: shared types and constants for the RTC write-port slice.
//   - rtc_wr_state_t : write-port FSM states
//   - RTC_AD_W / RTC_IDX_W : bus data width and shadow index width
//   - RTC_BUS_IDLE : inactive levels of the RTC pad controls
//   - rtc_bcd_bad() : true when either nibble of a byte is not a BCD digit
package rtc_pkg;

    localparam int unsigned RTC_AD_W  = 8;
    localparam int unsigned RTC_IDX_W = 4;

    typedef enum logic [3:0] {
        StIdle,
        StGrant,
        StASu,
        StAStb,
        StAHld,
        StDSu,
        StDStb,
        StDHld,
        StAck,
        StCool
    } rtc_wr_state_t;

    typedef struct packed {
        logic cs_n;
        logic wr_n;
        logic rd_n;
        logic ad_oe;
    } rtc_bus_ctl_t;

    localparam rtc_bus_ctl_t RTC_BUS_IDLE = '{cs_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1, ad_oe: 1'b0};

    function automatic logic rtc_bcd_bad(input logic [RTC_AD_W-1:0] value);
        return (value[7:4] > 4'd9) || (value[3:0] > 4'd9);
    endfunction

endpackage

// File: rtl/rtc_shadow_rf.sv
// rtc_shadow_rf: 16x8 shadow register file of the RTC registers.
// Ports:
//   CLK, reset            : clock, synchronous active-high reset (clears all entries)
//   ack_we/idx/data       : write port from the write FSM; wins on an index collision
//   snap_we/idx/data      : write port from the RTC snapshot reader
//   rd_idx, rd_data       : asynchronous read port
module rtc_shadow_rf
    import rtc_pkg::*;
(
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 ack_we,
    input  logic [RTC_IDX_W-1:0] ack_idx,
    input  logic [RTC_AD_W-1:0]  ack_data,
    input  logic                 snap_we,
    input  logic [RTC_IDX_W-1:0] snap_idx,
    input  logic [RTC_AD_W-1:0]  snap_data,
    input  logic [RTC_IDX_W-1:0] rd_idx,
    output logic [RTC_AD_W-1:0]  rd_data
);

    localparam int unsigned Depth = 2 ** RTC_IDX_W;

    logic [RTC_AD_W-1:0] mem [Depth];

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (snap_we) begin
                mem[snap_idx] <= snap_data;
            end
            // Issued last so the FSM write overrides a same-index snapshot.
            if (ack_we) begin
                mem[ack_idx] <= ack_data;
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/rtc_write_port.sv
// rtc_write_port: grants the user-control FSM access, serves shadow reads, and turns each
// write request into a timed two-phase (address, then data) cycle on the RTC muxed bus.
// Ports:
//   CLK, reset               : clock, synchronous active-high reset
//   req, grant, done_in      : access handshake with the control FSM
//   rd_idx, rd_data          : combinational shadow read
//   wr_req, wr_idx, wr_addr, wr_data, fin : write request and one-cycle completion pulse
//   snap_we, snap_idx, snap_data         : shadow load from the RTC reader
//   cs_n, wr_n, rd_n, a_d, ad_out, ad_oe : RTC pad interface (registered)
//   wr_err                   : one-cycle reject pulse alongside fin
// Build option: define RTC_BCD_CHECK_EN to reject writes whose data is not two BCD digits;
// otherwise data is written raw and wr_err stays 0.
module rtc_write_port
    import rtc_pkg::*;
#(
    parameter int unsigned T_SETUP = 1,
    parameter int unsigned T_PULSE = 2,
    parameter int unsigned T_HOLD  = 1
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 req,
    output logic                 grant,
    input  logic                 done_in,
    input  logic [RTC_IDX_W-1:0] rd_idx,
    output logic [RTC_AD_W-1:0]  rd_data,
    input  logic                 wr_req,
    input  logic [RTC_IDX_W-1:0] wr_idx,
    input  logic [RTC_AD_W-1:0]  wr_addr,
    input  logic [RTC_AD_W-1:0]  wr_data,
    output logic                 fin,
    input  logic                 snap_we,
    input  logic [RTC_IDX_W-1:0] snap_idx,
    input  logic [RTC_AD_W-1:0]  snap_data,
    output logic                 cs_n,
    output logic                 wr_n,
    output logic                 rd_n,
    output logic                 a_d,
    output logic [RTC_AD_W-1:0]  ad_out,
    output logic                 ad_oe,
    output logic                 wr_err
);

    // Counter reload values: a state lasts (load + 1) cycles.
    localparam logic [7:0] SuLoad   = 8'(T_SETUP - 1);
    localparam logic [7:0] StbLoad  = 8'(T_PULSE - 1);
    localparam logic [7:0] HldLoad  = 8'(T_HOLD - 1);
    localparam logic [7:0] CoolLoad = 8'd1;

    rtc_wr_state_t        state;
    logic [7:0]           cnt;
    logic [RTC_IDX_W-1:0] idx_q;
    logic [RTC_AD_W-1:0]  addr_q;
    logic [RTC_AD_W-1:0]  data_q;
    logic                 skip_wr;   // rejected write: ACK must not touch the shadow
    logic                 req_lost;  // req dropped during the bus cycle
    logic                 ack_we;

    assign rd_n   = RTC_BUS_IDLE.rd_n;
    assign ack_we = (state == StAck) && !skip_wr;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= StIdle;
            cnt      <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            skip_wr  <= 1'b0;
            req_lost <= 1'b0;
            grant    <= 1'b0;
            fin      <= 1'b0;
            wr_err   <= 1'b0;
            cs_n     <= RTC_BUS_IDLE.cs_n;
            wr_n     <= RTC_BUS_IDLE.wr_n;
            ad_oe    <= RTC_BUS_IDLE.ad_oe;
            a_d      <= 1'b0;
            ad_out   <= '0;
        end else begin
            fin    <= 1'b0;
            wr_err <= 1'b0;
            if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (!req) begin
                req_lost <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (req) begin
                        state <= StGrant;
                        grant <= 1'b1;
                    end
                end
                StGrant: begin
                    if (!req || done_in) begin
                        state <= StIdle;
                        grant <= 1'b0;
                    end else if (wr_req) begin
                        idx_q    <= wr_idx;
                        addr_q   <= wr_addr;
                        data_q   <= wr_data;
                        req_lost <= 1'b0;
`ifdef RTC_BCD_CHECK_EN
                        if (rtc_bcd_bad(wr_data)) begin
                            state   <= StAck;
                            skip_wr <= 1'b1;
                            fin     <= 1'b1;
                            wr_err  <= 1'b1;
                        end else
`endif
                        begin
                            state   <= StASu;
                            cnt     <= SuLoad;
                            skip_wr <= 1'b0;
                            cs_n    <= 1'b0;
                            ad_oe   <= 1'b1;
                            a_d     <= 1'b0;
                            ad_out  <= wr_addr;
                        end
                    end
                end
                StASu: begin
                    if (cnt == 8'd0) begin
                        state <= StAStb;
                        cnt   <= StbLoad;
                        wr_n  <= 1'b0;
                    end
                end
                StAStb: begin
                    if (cnt == 8'd0) begin
                        state <= StAHld;
                        cnt   <= HldLoad;
                        wr_n  <= 1'b1;
                    end
                end
                StAHld: begin
                    if (cnt == 8'd0) begin
                        state  <= StDSu;
                        cnt    <= SuLoad;
                        a_d    <= 1'b1;
                        ad_out <= data_q;
                    end
                end
                StDSu: begin
                    if (cnt == 8'd0) begin
                        state <= StDStb;
                        cnt   <= StbLoad;
                        wr_n  <= 1'b0;
                    end
                end
                StDStb: begin
                    if (cnt == 8'd0) begin
                        state <= StDHld;
                        cnt   <= HldLoad;
                        wr_n  <= 1'b1;
                    end
                end
                StDHld: begin
                    if (cnt == 8'd0) begin
                        state  <= StAck;
                        cs_n   <= RTC_BUS_IDLE.cs_n;
                        ad_oe  <= RTC_BUS_IDLE.ad_oe;
                        a_d    <= 1'b0;
                        ad_out <= '0;
                        fin    <= 1'b1;
                    end
                end
                StAck: begin
                    // A requester that let go mid-cycle gets its ACK, then loses the grant.
                    if (req_lost || !req) begin
                        state <= StIdle;
                        grant <= 1'b0;
                    end else begin
                        state <= StCool;
                        cnt   <= CoolLoad;
                    end
                end
                StCool: begin
                    if (cnt == 8'd0) begin
                        state <= StGrant;
                    end
                end
                default: begin
                    state <= StIdle;
                    grant <= 1'b0;
                end
            endcase
        end
    end

    rtc_shadow_rf u_shadow (
        .CLK       (CLK),
        .reset     (reset),
        .ack_we    (ack_we),
        .ack_idx   (idx_q),
        .ack_data  (data_q),
        .snap_we   (snap_we),
        .snap_idx  (snap_idx),
        .snap_data (snap_data),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data)
    );

endmodule
